// File: rtl/control_pkg.sv
// Shared encodings for the multi-cycle control unit, ALU and datapath.
package control_pkg;

  // Sequencer states; the ALU relies on DECODE being 1 to clear flagBRANCH.
  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_MEMORY    = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_IDLE      = 3'd5,
    ST_HALT      = 3'd6
  } state_t;

  // Opcode map; anything above OP_HALT is undefined.
  localparam logic [5:0] OP_ALU   = 6'd0;
  localparam logic [5:0] OP_LOAD  = 6'd1;
  localparam logic [5:0] OP_STORE = 6'd2;
  localparam logic [5:0] OP_JUMP  = 6'd3;
  localparam logic [5:0] OP_SRL   = 6'd4;
  localparam logic [5:0] OP_SLL   = 6'd5;
  localparam logic [5:0] OP_BEQ   = 6'd6;
  localparam logic [5:0] OP_BNQ   = 6'd7;
  localparam logic [5:0] OP_HALT  = 6'd8;

  // FUNCT codes that need a stretched EXECUTE.
  localparam logic [5:0] FUNCT_MUL = 6'd17;
  localparam logic [5:0] FUNCT_DIV = 6'd18;

  // flagALU operation classes.
  localparam logic [1:0] FLAG_IDLE   = 2'd0;
  localparam logic [1:0] FLAG_FUNCT  = 2'd1;
  localparam logic [1:0] FLAG_OPCODE = 2'd2;

  // PC source select.
  localparam logic [1:0] PC_PLUS1  = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;

  function automatic logic is_muldiv(input logic [5:0] op, input logic [5:0] funct);
    return (op == OP_ALU) && ((funct == FUNCT_MUL) || (funct == FUNCT_DIV));
  endfunction

  function automatic logic is_illegal(input logic [5:0] op);
    return op > OP_HALT;
  endfunction

endpackage

// File: rtl/exec_stall_counter.sv
// Down-counter that holds the sequencer in EXECUTE for multi-cycle operations.
module exec_stall_counter #(
  parameter int WIDTH = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             dec,
  output logic             zero
);

  logic [WIDTH-1:0] count_reg;

  // Reset clears, load has priority over decrement, decrement saturates at zero.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_value;
    end else if (dec && (count_reg != '0)) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign zero = (count_reg == '0);

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle sequencer: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK with strobes
// decoded combinationally from the current state and latched instruction.
module multicycle_control_unit
  import control_pkg::*;
#(
  parameter int bitsOP        = 6,
  parameter int st            = 3,
  parameter int flag          = 2,
  parameter int MULDIV_CYCLES = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              run,
  input  logic              mem_ready,
  input  logic [bitsOP-1:0] OPCODE,
  input  logic [bitsOP-1:0] FUNCT,
  input  logic              flagBRANCH,
  output logic [st-1:0]     State,
  output logic [flag-1:0]   flagALU,
  output logic              ir_write,
  output logic              pc_write,
  output logic [1:0]        pc_src,
  output logic              mem_read,
  output logic              mem_write,
  output logic              reg_write,
  output logic              wb_sel_mem,
  output logic              halted,
  output logic              illegal
);

  // Counter width; a single-cycle configuration still needs one bit.
  localparam int CW = (MULDIV_CYCLES > 1) ? $clog2(MULDIV_CYCLES) : 1;
  localparam logic [CW-1:0] MULDIV_LOAD = CW'(MULDIV_CYCLES - 1);

  state_t            state_reg;
  logic [bitsOP-1:0] op_reg;
  logic [bitsOP-1:0] funct_reg;
  logic              illegal_reg;
  logic              cnt_zero;
  logic              cnt_load;
  logic              cnt_dec;
  logic [CW-1:0]     cnt_value;

  // The counter is loaded once per instruction in DECODE and counts down in EXECUTE.
  assign cnt_load  = (state_reg == ST_DECODE);
  assign cnt_dec   = (state_reg == ST_EXECUTE);
  assign cnt_value = is_muldiv(OPCODE, FUNCT) ? MULDIV_LOAD : '0;

  exec_stall_counter #(
    .WIDTH(CW)
  ) u_stall (
    .clock     (clock),
    .reset     (reset),
    .load      (cnt_load),
    .load_value(cnt_value),
    .dec       (cnt_dec),
    .zero      (cnt_zero)
  );

  // State sequencing, instruction latch and sticky illegal flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg   <= ST_IDLE;
      op_reg      <= '0;
      funct_reg   <= '0;
      illegal_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (run) state_reg <= ST_FETCH;
        end
        ST_FETCH: begin
          if (mem_ready) state_reg <= ST_DECODE;
        end
        ST_DECODE: begin
          op_reg    <= OPCODE;
          funct_reg <= FUNCT;
          if (OPCODE == OP_JUMP) begin
            state_reg <= ST_FETCH;
          end else if (OPCODE == OP_HALT) begin
            state_reg <= ST_HALT;
          end else if (is_illegal(OPCODE)) begin
            illegal_reg <= 1'b1;
            state_reg   <= ST_HALT;
          end else begin
            state_reg <= ST_EXECUTE;
          end
        end
        ST_EXECUTE: begin
          if (cnt_zero) begin
            state_reg <= ((op_reg == OP_LOAD) || (op_reg == OP_STORE)) ? ST_MEMORY : ST_WRITEBACK;
          end
        end
        ST_MEMORY: begin
          if (mem_ready) state_reg <= (op_reg == OP_STORE) ? ST_FETCH : ST_WRITEBACK;
        end
        ST_WRITEBACK: begin
          state_reg <= ST_FETCH;
        end
        ST_HALT: begin
          state_reg <= ST_HALT;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  // Strobe decode; everything is forced low while reset is asserted.
  always_comb begin
    flagALU    = FLAG_IDLE;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = PC_PLUS1;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    wb_sel_mem = 1'b0;
    halted     = 1'b0;
    if (!reset) begin
      case (state_reg)
        ST_FETCH: begin
          mem_read = 1'b1;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            pc_src   = PC_PLUS1;
          end
        end
        ST_DECODE: begin
          if (OPCODE == OP_JUMP) begin
            pc_write = 1'b1;
            pc_src   = PC_JUMP;
          end
        end
        ST_EXECUTE: begin
          if ((op_reg == OP_ALU) || (op_reg == OP_LOAD) || (op_reg == OP_STORE)) begin
            flagALU = FLAG_FUNCT;
          end else if ((op_reg >= OP_SRL) && (op_reg <= OP_BNQ)) begin
            flagALU = FLAG_OPCODE;
          end
        end
        ST_MEMORY: begin
          mem_read  = (op_reg == OP_LOAD);
          mem_write = (op_reg == OP_STORE);
        end
        ST_WRITEBACK: begin
          if ((op_reg == OP_ALU) || (op_reg == OP_SRL) || (op_reg == OP_SLL)) begin
            reg_write = 1'b1;
          end else if (op_reg == OP_LOAD) begin
            reg_write  = 1'b1;
            wb_sel_mem = 1'b1;
          end else if ((op_reg == OP_BEQ) || (op_reg == OP_BNQ)) begin
            pc_write = flagBRANCH;
            pc_src   = PC_BRANCH;
          end
        end
        ST_HALT: begin
          halted = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign State   = st'(state_reg);
  assign illegal = illegal_reg;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Randomized instruction-stream bench for multicycle_control_unit. The model
// expands each instruction into its expected per-cycle trace (inputs to drive
// plus expected outputs), then the whole trace is played against the DUT.
module tb_multicycle_control_unit;

  localparam int MD = 4;

  // Architectural state numbers.
  localparam int S_FETCH = 0, S_DECODE = 1, S_EXEC = 2, S_MEM = 3, S_WB = 4, S_IDLE = 5, S_HALT = 6;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       run = 1'b0;
  logic       mem_ready = 1'b0;
  logic [5:0] OPCODE = '0;
  logic [5:0] FUNCT = '0;
  logic       flagBRANCH = 1'b0;
  logic [2:0] State;
  logic [1:0] flagALU;
  logic       ir_write, pc_write, mem_read, mem_write, reg_write, wb_sel_mem, halted, illegal;
  logic [1:0] pc_src;

  multicycle_control_unit #(
    .bitsOP(6), .st(3), .flag(2), .MULDIV_CYCLES(MD)
  ) dut (
    .clock(clock), .reset(reset), .run(run), .mem_ready(mem_ready),
    .OPCODE(OPCODE), .FUNCT(FUNCT), .flagBRANCH(flagBRANCH),
    .State(State), .flagALU(flagALU), .ir_write(ir_write), .pc_write(pc_write),
    .pc_src(pc_src), .mem_read(mem_read), .mem_write(mem_write),
    .reg_write(reg_write), .wb_sel_mem(wb_sel_mem), .halted(halted), .illegal(illegal)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       tag;
    bit          rst;
    bit          run;
    bit          rdy;
    bit          fb;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [15:0] want;
  } rec_t;

  rec_t q[$];
  int   tests = 0;
  int   fails = 0;
  bit   ill_m = 1'b0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s got=%b want=%b (st,flag,ir,pcw,pcsrc,mr,mw,rw,wbm,hlt,ill)", tag, got, want);
    end
  endtask

  function automatic logic [15:0] vec(input int s, input int f, input bit ir, input bit pcw,
                                      input int pcs, input bit mr, input bit mw, input bit rw,
                                      input bit wbm, input bit hl, input bit il);
    return {1'b0, 3'(s), 2'(f), ir, pcw, 2'(pcs), mr, mw, rw, wbm, hl, il};
  endfunction

  function automatic bit rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [5:0] r6();
    return 6'($urandom_range(0, 63));
  endfunction

  task automatic push(input string tag, input bit rst, input bit rn, input bit rdy, input bit fb,
                      input logic [5:0] op, input logic [5:0] fn, input logic [15:0] want);
    rec_t r;
    r.tag = tag; r.rst = rst; r.run = rn; r.rdy = rdy; r.fb = fb;
    r.op = op; r.fn = fn; r.want = want;
    q.push_back(r);
  endtask

  // Expected trace of one instruction, starting in FETCH.
  task automatic gen_instr(input logic [5:0] op, input logic [5:0] fn, input bit fb,
                           input int fwait, input int mwait);
    int  n;
    int  fl;
    bit  br;
    bit  rw;
    for (int i = 0; i < fwait; i++)
      push("fetch_wait", 0, rb(), 0, rb(), r6(), r6(), vec(S_FETCH, 0, 0, 0, 0, 1, 0, 0, 0, 0, ill_m));
    push("fetch", 0, rb(), 1, rb(), r6(), r6(), vec(S_FETCH, 0, 1, 1, 0, 1, 0, 0, 0, 0, ill_m));
    if (op == 6'd3) begin
      push("decode_jump", 0, rb(), rb(), rb(), op, fn, vec(S_DECODE, 0, 0, 1, 2, 0, 0, 0, 0, 0, ill_m));
      return;
    end
    push("decode", 0, rb(), rb(), rb(), op, fn, vec(S_DECODE, 0, 0, 0, 0, 0, 0, 0, 0, 0, ill_m));
    if (op >= 6'd8) begin
      if (op > 6'd8) ill_m = 1'b1;
      return;
    end
    n  = (op == 6'd0 && (fn == 6'd17 || fn == 6'd18)) ? MD : 1;
    fl = (op <= 6'd2) ? 1 : 2;
    for (int i = 0; i < n; i++)
      push("execute", 0, rb(), rb(), rb(), r6(), r6(), vec(S_EXEC, fl, 0, 0, 0, 0, 0, 0, 0, 0, ill_m));
    if (op == 6'd1 || op == 6'd2) begin
      for (int i = 0; i < mwait; i++)
        push("mem_wait", 0, rb(), 0, rb(), r6(), r6(),
             vec(S_MEM, 0, 0, 0, 0, op == 6'd1, op == 6'd2, 0, 0, 0, ill_m));
      push("mem", 0, rb(), 1, rb(), r6(), r6(),
           vec(S_MEM, 0, 0, 0, 0, op == 6'd1, op == 6'd2, 0, 0, 0, ill_m));
      if (op == 6'd2) return;
    end
    br = (op == 6'd6 || op == 6'd7);
    rw = (op == 6'd0 || op == 6'd1 || op == 6'd4 || op == 6'd5);
    push("writeback", 0, rb(), rb(), fb, r6(), r6(),
         vec(S_WB, 0, 0, br ? fb : 1'b0, br ? 1 : 0, 0, 0, rw, op == 6'd1, 0, ill_m));
  endtask

  task automatic idle_and_run();
    push("idle", 0, 0, rb(), rb(), r6(), r6(), vec(S_IDLE, 0, 0, 0, 0, 0, 0, 0, 0, 0, ill_m));
    push("idle_run", 0, 1, rb(), rb(), r6(), r6(), vec(S_IDLE, 0, 0, 0, 0, 0, 0, 0, 0, 0, ill_m));
  endtask

  // Cycles spent in HALT (run pulses included), then a reset back to IDLE.
  task automatic halt_then_reset(input int cycles);
    for (int i = 0; i < cycles; i++)
      push("halt", 0, rb(), rb(), rb(), r6(), r6(), vec(S_HALT, 0, 0, 0, 0, 0, 0, 0, 0, 1, ill_m));
    push("halt_reset", 1, 1, 1, rb(), r6(), r6(), vec(S_HALT, 0, 0, 0, 0, 0, 0, 0, 0, 0, ill_m));
    ill_m = 1'b0;
  endtask

  task automatic play();
    rec_t r;
    int   idx = 0;
    while (q.size() > 0) begin
      r = q.pop_front();
      @(negedge clock);
      reset = r.rst; run = r.run; mem_ready = r.rdy; flagBRANCH = r.fb;
      OPCODE = r.op; FUNCT = r.fn;
      #1;
      check($sformatf("%s#%0d", r.tag, idx),
            {1'b0, State, flagALU, ir_write, pc_write, pc_src, mem_read, mem_write,
             reg_write, wb_sel_mem, halted, illegal}, r.want);
      idx++;
    end
  endtask

  initial begin
    logic [5:0] op;
    logic [5:0] fn;

    // Reset held from time 0; by the first check State is already IDLE.
    push("reset", 1, 1, 1, 1, r6(), r6(), vec(S_IDLE, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    push("reset2", 1, 0, 1, 1, r6(), r6(), vec(S_IDLE, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    idle_and_run();

    // Directed instructions.
    gen_instr(6'd0, 6'd0, 0, 0, 0);   // ADD
    gen_instr(6'd0, 6'd17, 0, 0, 0);  // MUL
    gen_instr(6'd1, 6'd1, 0, 0, 3);   // LOAD, three memory wait cycles
    gen_instr(6'd6, 6'd0, 1, 0, 0);   // BEQ taken
    gen_instr(6'd6, 6'd0, 0, 0, 0);   // BEQ not taken
    gen_instr(6'd7, 6'd0, 1, 1, 0);   // BNQ taken
    gen_instr(6'd3, 6'd0, 0, 2, 0);   // JUMP
    gen_instr(6'd2, 6'd1, 0, 1, 2);   // STORE
    gen_instr(6'd0, 6'd18, 1, 0, 0);  // DIV
    gen_instr(6'd4, 6'd5, 0, 0, 0);   // SRL
    gen_instr(6'd5, 6'd5, 0, 0, 0);   // SLL

    // Random legal instruction stream.
    for (int k = 0; k < 40; k++) begin
      op = 6'($urandom_range(0, 7));
      case ($urandom_range(0, 2))
        0: fn = 6'd17;
        1: fn = 6'd18;
        default: fn = r6();
      endcase
      gen_instr(op, fn, rb(), $urandom_range(0, 2), $urandom_range(0, 2));
    end

    // Undefined opcode: HALT with sticky illegal, run ignored, reset clears it.
    gen_instr(6'd12, 6'd0, 0, 0, 0);
    halt_then_reset(3);
    idle_and_run();

    // HALT opcode: halted without illegal.
    gen_instr(6'd8, 6'd0, 0, 1, 0);
    halt_then_reset(2);
    idle_and_run();

    // Reset during the second MUL EXECUTE cycle.
    push("fetch", 0, 0, 1, 0, r6(), r6(), vec(S_FETCH, 0, 1, 1, 0, 1, 0, 0, 0, 0, 0));
    push("decode_mul", 0, 0, 0, 0, 6'd0, 6'd17, vec(S_DECODE, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    push("exec_mul1", 0, 1, 1, 0, r6(), r6(), vec(S_EXEC, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    push("exec_mul_reset", 1, 1, 1, 1, r6(), r6(), vec(S_EXEC, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    idle_and_run();
    gen_instr(6'd0, 6'd0, 0, 0, 0);   // ADD after abort: single EXECUTE cycle
    gen_instr(6'd0, 6'd17, 0, 0, 0);  // full-length MUL after abort

    play();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Multi-cycle sequencer for the processor datapath around the ALU.
- Drives the 3-bit State bus and the 2-bit flagALU select consumed by the ALU.
- Generates PC, instruction-register, register-file and memory strobes.
- Stretches EXECUTE for multiply/divide and resolves branches from the ALU's registered flagBRANCH.

Parameters:
- bitsOP, 6, opcode/funct field width
- st, 3, State bus width
- flag, 2, flagALU width
- MULDIV_CYCLES, 4, EXECUTE length for FUNCT 17/18 (must be >=1)

Ports:
- clock  input  1  system clock, all logic on posedge
- reset  input  1  synchronous, active-high; sampled on posedge clock only
- run  input  1  start pulse; leaves IDLE
- mem_ready  input  1  memory handshake: access completes in the cycle it is high
- OPCODE  input  6  from instruction register, valid from DECODE onward
- FUNCT  input  6  from instruction register, valid from DECODE onward
- flagBRANCH  input  1  registered branch result from the ALU
- State  output  3  current state
- flagALU  output  2  ALU operation class: 0 idle, 1 FUNCT-type, 2 OPCODE-type
- ir_write  output  1  load instruction register
- pc_write  output  1  update PC
- pc_src  output  2  PC source: 0 PC+1, 1 branch target, 2 jump target
- mem_read  output  1  memory read request
- mem_write  output  1  memory write request
- reg_write  output  1  register-file write enable
- wb_sel_mem  output  1  write-back data source: 1 memory, 0 ALU RDvalue
- halted  output  1  core stopped
- illegal  output  1  sticky flag: an undefined opcode was decoded

Behaviour:
- Opcode map:
  - 0 ALU (FUNCT selects the operation)
  - 1 LOAD; 2 STORE (instruction encodes FUNCT=1, ADDI, for address calculation)
  - 3 JUMP
  - 4 SRL; 5 SLL; 6 BEQ; 7 BNQ
  - 8 HALT
  - 9-63 illegal
- State encoding: FETCH=0, DECODE=1, EXECUTE=2, MEMORY=3, WRITEBACK=4, IDLE=5, HALT=6. The ALU relies on DECODE=1 to clear flagBRANCH.
- Registers: State, op_q/funct_q (latched in DECODE), execute down-counter, illegal.
- Strobes are combinational from State, op_q, funct_q, mem_ready and flagBRANCH. All strobes are 0 unless stated below.
- Reset (any cycle, including mid-access or mid-count):
  - next State=IDLE, counter=0, illegal=0.
  - All strobes 0 in the reset cycle's outputs.
- IDLE: run=1 -> FETCH. Otherwise stay.
- FETCH:
  - mem_read=1.
  - When mem_ready=1: ir_write=1, pc_write=1, pc_src=0 -> DECODE.
  - Otherwise hold with no PC change.
- DECODE:
  - Latch op_q/funct_q.
  - JUMP: pc_write=1, pc_src=2 -> FETCH.
  - HALT -> HALT.
  - Illegal opcode: set illegal -> HALT.
  - Otherwise -> EXECUTE. If op=0 and FUNCT in {17,18}, load counter with MULDIV_CYCLES-1; else load 0.
- EXECUTE:
  - flagALU=1 for op 0/1/2; flagALU=2 for op 4-7.
  - While counter!=0: decrement and stay.
  - At counter=0: LOAD/STORE -> MEMORY; all others -> WRITEBACK.
  - Total EXECUTE length is 1 cycle, or MULDIV_CYCLES for mul/div.
- MEMORY:
  - LOAD drives mem_read=1; STORE drives mem_write=1.
  - Hold until mem_ready=1. Then STORE -> FETCH; LOAD -> WRITEBACK.
- WRITEBACK (RDvalue and flagBRANCH have been valid since the last EXECUTE edge):
  - op 0/4/5: reg_write=1, wb_sel_mem=0.
  - LOAD: reg_write=1, wb_sel_mem=1.
  - BEQ/BNQ: pc_write=flagBRANCH, pc_src=1, no reg_write.
  - -> FETCH.
- HALT: halted=1. run is ignored; only reset exits.
- Simultaneous events:
  - reset beats run and mem_ready.
  - run while not IDLE is ignored.
  - mem_ready outside FETCH/MEMORY is ignored.
- CPI: ALU/shift/branch 4, STORE 4, LOAD 5, JUMP 2, each plus memory wait cycles. Mul/div add MULDIV_CYCLES-1.

Decomposition:
- Shared package control_pkg holds:
  - State encodings
  - opcode constants
  - FUNCT_MUL=17, FUNCT_DIV=18
  - flagALU codes
  - pc_src codes
- These constants are also used by the ALU and datapath.
- One natural sub-module: exec_stall_counter (load, decrement, zero flag, width clog2(MULDIV_CYCLES)).

Test Plan:
- Reset, run, ADD (op0/f0), mem_ready always 1 -> States 5,0,1,2,4,0. flagALU=1 only in EXECUTE. reg_write=1 only in WRITEBACK.
- MUL (f17), MULDIV_CYCLES=4 -> State=2 for exactly 4 cycles, flagALU=1 throughout, then WRITEBACK.
- LOAD with mem_ready low 3 cycles in MEMORY -> mem_read held 3 cycles. WRITEBACK then has reg_write=1 and wb_sel_mem=1; total 8 cycles.
- BEQ with flagBRANCH=1 -> WRITEBACK shows pc_write=1, pc_src=1. With flagBRANCH=0 -> pc_write=0.
- Opcode 12 decoded -> HALT, illegal=1, halted=1. A run pulse has no effect; reset clears illegal.
- Reset asserted during the second MUL EXECUTE cycle -> next State=5, all strobes 0, counter=0.
